rmio_sched: RTL
===============

RMIO_SCHED -- requirements
Module: rmio_sched

Interface
REQ-001 SHALL have parameter INPUT_NUM, default 4, meaning number of EU operand slots.
REQ-002 SHALL have parameter OUTPUT_NUM, default 2, meaning number of EU result slots.
REQ-003 SHALL have parameter DATA_W, default 1408, meaning operand/result width in bits.
REQ-004 SHALL have parameter LAT_W, default 8, meaning width of the EU latency field.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-008 cmd_in_mask  in  INPUT_NUM  operand slots to load.
REQ-009 cmd_out_mask  in  OUTPUT_NUM  result slots to drain.
REQ-010 cmd_lat  in  LAT_W  wait cycles between the last operand write and the first result read.
REQ-011 rd_req  out  1  operand fetch request to RF RAM.
REQ-012 rd_idx  out  $clog2(INPUT_NUM) (min 1)  slot index of the fetch.
REQ-013 rd_valid / rd_data  in / in  1 / DATA_W  fetch return.
REQ-014 input_data / input_we  out / out  DATA_W / INPUT_NUM  EU operand write port.
REQ-015 output_re / output_data  out / in  OUTPUT_NUM / DATA_W  EU result read port; output_data is combinationally valid while output_re is asserted.
REQ-016 wb_valid / wb_ready  out / in  1 / 1  result writeback handshake.
REQ-017 wb_idx / wb_data  out / out  $clog2(OUTPUT_NUM) (min 1) / DATA_W  writeback slot and data.
REQ-018 busy / done  out / out  1 / 1  command in flight / one-cycle completion pulse.

Function
REQ-019 SHALL implement the states IDLE, LOAD, WAIT, DRAIN and DONE.
REQ-020 IDLE: cmd_ready=1; on cmd_valid, latch both masks and cmd_lat; go to LOAD if in_mask is nonzero, else to WAIT.
REQ-021 LOAD: rd_req=1, rd_idx=lowest set bit of the remaining in_mask; rd_req/rd_idx SHALL stay stable until rd_valid.
REQ-022 On a rd_valid cycle in LOAD: next cycle input_data=rd_data and input_we=one-hot(rd_idx) for exactly one cycle; that bit is cleared.
REQ-023 rd_valid in the same cycle the last bit clears: transition to WAIT; rd_req deasserts that next cycle.
REQ-024 WAIT: counter is loaded with cmd_lat on entry and decrements once per cycle; at counter==0 go to DRAIN; cmd_lat=0 gives exactly one WAIT cycle.
REQ-025 DRAIN: output_re=one-hot(lowest set bit of the remaining out_mask), wb_valid=1, wb_idx=that bit, wb_data=output_data, all held until wb_ready.
REQ-026 On wb_valid&&wb_ready: clear the bit; the next slot SHALL be presented the following cycle (no bubble); when empty go to DONE.
REQ-027 An empty out_mask on DRAIN entry SHALL go to DONE in one cycle, with no output_re.
REQ-028 DONE: done=1 for one cycle, then IDLE; a new command is accepted no earlier than the cycle after DONE.
REQ-029 busy=1 in every state except IDLE; cmd_ready=0 whenever busy; cmd_valid while busy is ignored.
REQ-030 rd_valid outside LOAD SHALL be ignored.
REQ-031 input_we and output_re SHALL each be one-hot or zero in every cycle; input_data SHALL hold its last value when input_we=0.
REQ-032 Slots are serviced in ascending index order; unselected slots are never written or read.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, clear the masks and counter, and drive cmd_ready=1 and all other outputs 0 (input_data=0, wb_data follows output_data only while in DRAIN, else 0).
REQ-034 Reset mid-command SHALL abandon it; no further input_we, output_re or done is issued for it.

Verification
REQ-035 in_mask=4'b1010, out_mask=2'b01, lat=3, rd_valid 2 cycles after each rd_req -> input_we 4'b0010 then 4'b1000; 3 WAIT cycles; output_re=01; wb_idx=0; done once.
REQ-036 in_mask=0, out_mask=0, lat=0 -> IDLE->WAIT->DRAIN->DONE->IDLE in 4 cycles; no rd_req, input_we or output_re.
REQ-037 out_mask=2'b11 with wb_ready low for 5 cycles on slot 0 -> output_re=01 and wb_data stable for 5 cycles; then slot 1 presented the very next cycle.
REQ-038 cmd_valid held high during busy with a second command -> it is accepted only after done, and its masks are serviced.
REQ-039 rst_n asserted in WAIT -> same-cycle busy=0, cmd_ready=1; no later output_re or done.
REQ-040 Spurious rd_valid in IDLE/WAIT -> no input_we pulse.

Source files
------------

// File: rtl/rmio_sched.sv
// rmio_sched: sequences one execution-unit command.
// It fetches the selected operands from the register file into the EU operand slots,
// waits out the EU latency, then drains the selected result slots to writeback.
module rmio_sched #(
    parameter int INPUT_NUM  = 4,
    parameter int OUTPUT_NUM = 2,
    parameter int DATA_W     = 1408,
    parameter int LAT_W      = 8,
    localparam int IN_IDX_W  = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1,
    localparam int OUT_IDX_W = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [INPUT_NUM-1:0]  cmd_in_mask,
    input  logic [OUTPUT_NUM-1:0] cmd_out_mask,
    input  logic [LAT_W-1:0]      cmd_lat,
    output logic                  rd_req,
    output logic [IN_IDX_W-1:0]   rd_idx,
    input  logic                  rd_valid,
    input  logic [DATA_W-1:0]     rd_data,
    output logic [DATA_W-1:0]     input_data,
    output logic [INPUT_NUM-1:0]  input_we,
    output logic [OUTPUT_NUM-1:0] output_re,
    input  logic [DATA_W-1:0]     output_data,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [OUT_IDX_W-1:0]  wb_idx,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [INPUT_NUM-1:0]    in_mask_reg, in_mask_next;
    logic [OUTPUT_NUM-1:0]   out_mask_reg, out_mask_next;
    logic [LAT_W-1:0]        cnt_reg, cnt_next;
    logic [INPUT_NUM-1:0]    input_we_reg;
    logic [DATA_W-1:0]       input_data_reg;

    // Lowest pending slot as a one-hot vector (x & -x isolates the lowest set bit).
    logic [INPUT_NUM-1:0]    in_low;
    logic [OUTPUT_NUM-1:0]   out_low;
    logic [IN_IDX_W-1:0]     in_low_idx;
    logic [OUT_IDX_W-1:0]    out_low_idx;

    assign in_low  = in_mask_reg & (~in_mask_reg + INPUT_NUM'(1));
    assign out_low = out_mask_reg & (~out_mask_reg + OUTPUT_NUM'(1));

    // Binary index of the lowest pending operand slot.
    always_comb begin
        in_low_idx = '0;
        for (int i = 0; i < INPUT_NUM; i++) begin
            if (in_low[i]) in_low_idx = IN_IDX_W'(i);
        end
    end

    // Binary index of the lowest pending result slot.
    always_comb begin
        out_low_idx = '0;
        for (int i = 0; i < OUTPUT_NUM; i++) begin
            if (out_low[i]) out_low_idx = OUT_IDX_W'(i);
        end
    end

    // State, pending masks and latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            in_mask_reg  <= '0;
            out_mask_reg <= '0;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            in_mask_reg  <= in_mask_next;
            out_mask_reg <= out_mask_next;
            cnt_reg      <= cnt_next;
        end
    end

    // Operand write port: one-cycle write strobe one cycle after each accepted fetch;
    // the data register holds its value between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            input_we_reg   <= '0;
            input_data_reg <= '0;
        end else if (state_reg == ST_LOAD && rd_valid) begin
            input_we_reg   <= in_low;
            input_data_reg <= rd_data;
        end else begin
            input_we_reg   <= '0;
        end
    end

    assign input_we   = input_we_reg;
    assign input_data = input_data_reg;

    // Next-state logic and handshake outputs.
    // The counter is loaded at command accept and only moves in WAIT; WAIT lasts
    // max(cmd_lat, 1) cycles, leaving as the decremented count reaches zero.
    always_comb begin
        state_next    = state_reg;
        in_mask_next  = in_mask_reg;
        out_mask_next = out_mask_reg;
        cnt_next      = cnt_reg;
        cmd_ready     = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        rd_req        = 1'b0;
        rd_idx        = '0;
        output_re     = '0;
        wb_valid      = 1'b0;
        wb_idx        = '0;
        wb_data       = '0;
        case (state_reg)
            ST_IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    in_mask_next  = cmd_in_mask;
                    out_mask_next = cmd_out_mask;
                    cnt_next      = cmd_lat;
                    state_next    = (cmd_in_mask != '0) ? ST_LOAD : ST_WAIT;
                end
            end
            ST_LOAD: begin
                rd_req = 1'b1;
                rd_idx = in_low_idx;
                if (rd_valid) begin
                    in_mask_next = in_mask_reg & ~in_low;
                    if (in_mask_next == '0) state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_reg <= LAT_W'(1)) begin
                    cnt_next   = '0;
                    state_next = ST_DRAIN;
                end else begin
                    cnt_next = cnt_reg - LAT_W'(1);
                end
            end
            ST_DRAIN: begin
                wb_data = output_data;
                if (out_mask_reg == '0) begin
                    state_next = ST_DONE;
                end else begin
                    output_re = out_low;
                    wb_valid  = 1'b1;
                    wb_idx    = out_low_idx;
                    if (wb_ready) begin
                        out_mask_next = out_mask_reg & ~out_low;
                        if (out_mask_next == '0) state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
